axis_slave: RTL and testbench



---
 rtl/axis_pkg.sv | 10 +
 rtl/axis_slave_if.sv | 25 ++
 rtl/axis_rx_fifo.sv | 43 ++++
 rtl/axis_slave.sv | 46 ++++
 tb/tb_axis_slave.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI-Stream widths and the buffered beat type
package axis_pkg;
    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_USER_W = 2;
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_USER_W-1:0] user;
        logic                   last;
    } axis_beat_t;
endpackage

// File: rtl/axis_slave_if.sv
// axis_slave_if: AXI-Stream input side plus backend head-of-buffer side
interface axis_slave_if import axis_pkg::*; #(parameter int FIFO_DEPTH = 4);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic                   axis_tvalid;
    logic [AXIS_DATA_W-1:0] axis_tdata;
    logic [3:0]             axis_tstrb;
    logic [3:0]             axis_tkeep;
    logic                   axis_tlast;
    logic [AXIS_USER_W-1:0] axis_tuser;
    logic                   axis_tready;
    logic [AXIS_DATA_W-1:0] bk_data;
    logic [AXIS_USER_W-1:0] bk_user;
    logic                   bk_last;
    logic                   bk_valid;
    logic                   bk_ready;
    logic [CW-1:0]          bk_count;
    modport master (
        output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser, bk_ready,
        input  axis_tready, bk_data, bk_user, bk_last, bk_valid, bk_count
    );
    modport slave (
        input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser, bk_ready,
        output axis_tready, bk_data, bk_user, bk_last, bk_valid, bk_count
    );
endinterface

// File: rtl/axis_rx_fifo.sv
// axis_rx_fifo: synchronous beat FIFO; storage is unreset, head reads zero while empty
module axis_rx_fifo import axis_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic       axi_aclk,
    input  logic       axi_aresetn,
    input  logic       i_push,
    input  logic       i_pop,
    input  axis_beat_t i_wdata,
    output axis_beat_t o_rdata,
    output logic [CW-1:0] o_count,
    output logic       o_full,
    output logic       o_empty
);
    axis_beat_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge axi_aclk)
        if (w_push) r_mem[r_wr] <= i_wdata;
    // power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/axis_slave.sv
// axis_slave: AXI-Stream sink buffering beats for a backend consumer
module axis_slave import axis_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic axi_aclk,
    input  logic axi_aresetn,
    axis_slave_if.slave s
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    axis_beat_t    w_wbeat;
    axis_beat_t    w_rbeat;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_tready;
    logic          w_unused_sideband;
    assign w_unused_sideband = ^{s.axis_tstrb, s.axis_tkeep};
    assign w_wbeat     = '{data: s.axis_tdata, user: s.axis_tuser, last: s.axis_tlast};
    assign w_push      = s.axis_tvalid && r_tready;
    assign w_pop       = s.bk_ready && !w_empty;
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
    axis_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_wdata     (w_wbeat),
        .o_rdata     (w_rbeat),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );
    // tready is a flop tracking next-cycle occupancy so it stays low in reset
    always_ff @(posedge axi_aclk or negedge axi_aresetn)
        if (!axi_aresetn) r_tready <= 1'b0;
        else r_tready <= w_count_nxt < CW'(FIFO_DEPTH);
    assign s.axis_tready = r_tready && !w_full;
    assign s.bk_valid    = !w_empty;
    assign s.bk_data     = w_rbeat.data;
    assign s.bk_user     = w_rbeat.user;
    assign s.bk_last     = w_rbeat.last;
    assign s.bk_count    = w_count;
endmodule

// File: tb/tb_axis_slave.sv
// tb_axis_slave: directed stimulus with a scoreboard queue checked on every backend pop
module tb_axis_slave;
    import axis_pkg::*;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic rand_bp = 1'b0;
    logic track = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    int maxc = 0;
    axis_beat_t q[$];
    axis_slave_if #(.FIFO_DEPTH(4)) m ();
    axis_slave #(.FIFO_DEPTH(4)) dut (.axi_aclk(clk), .axi_aresetn(aresetn), .s(m));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (aresetn && m.bk_valid && m.bk_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected nothing", m.bk_data);
            end else begin
                axis_beat_t e;
                e = q.pop_front();
                if ({m.bk_data, m.bk_user, m.bk_last} !== e) begin
                    n_err++;
                    $display("FAIL pop_beat: got %0h/%0h/%0h expected %0h/%0h/%0h",
                             m.bk_data, m.bk_user, m.bk_last, e.data, e.user, e.last);
                end
            end
        end
        if (track && int'(m.bk_count) > maxc) maxc = int'(m.bk_count);
    end
    always @(posedge clk) begin
        #3;
        if (rand_bp) m.bk_ready = 1'($urandom_range(0, 1));
    end
    task automatic send(input logic [31:0] d, input logic [1:0] u, input logic l);
        int n = 0;
        m.axis_tvalid = 1'b1;
        m.axis_tdata  = d;
        m.axis_tuser  = u;
        m.axis_tlast  = l;
        @(negedge clk);
        while (!m.axis_tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!m.axis_tready) begin
            check("send_ready", m.axis_tready, 1);
            @(posedge clk);
            #1 m.axis_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        q.push_back('{data: d, user: u, last: l});
        #1 m.axis_tvalid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        m.bk_ready = 1'b1;
        @(negedge clk);
        while (m.bk_count != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_count", m.bk_count, 0);
        m.bk_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int t0;
        m.axis_tvalid = 1'b0;
        m.axis_tdata  = '0;
        m.axis_tstrb  = 4'hF;
        m.axis_tkeep  = 4'hF;
        m.axis_tlast  = 1'b0;
        m.axis_tuser  = '0;
        m.bk_ready    = 1'b0;
        #1;
        check("rst_tready", m.axis_tready, 0);
        check("rst_valid", m.bk_valid, 0);
        check("rst_count", m.bk_count, 0);
        check("rst_data", {m.bk_data, m.bk_user, m.bk_last}, 0);
        repeat (2) @(posedge clk);
        #2 aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_tready", m.axis_tready, 1);
        // single beat
        m.bk_ready = 1'b1;
        check("single_pre_valid", m.bk_valid, 0);
        send(32'hDEADBEEF, 2'b10, 1'b1);
        check("single_valid", m.bk_valid, 1);
        check("single_fields", {m.bk_data, m.bk_user, m.bk_last}, {32'hDEADBEEF, 2'b10, 1'b1});
        @(posedge clk);
        #1;
        check("single_count", m.bk_count, 0);
        // fill to full
        m.bk_ready = 1'b0;
        send(32'h1, 2'd0, 1'b0);
        send(32'h2, 2'd1, 1'b0);
        send(32'h3, 2'd2, 1'b0);
        send(32'h4, 2'd3, 1'b1);
        check("full_tready", m.axis_tready, 0);
        check("full_count", m.bk_count, 4);
        m.axis_tvalid = 1'b1;
        m.axis_tdata  = 32'h5;
        repeat (3) @(posedge clk);
        #1;
        m.axis_tvalid = 1'b0;
        check("full_hold_count", m.bk_count, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stable_head", {m.bk_data, m.bk_user, m.bk_last}, {32'h1, 2'd0, 1'b0});
        end
        m.bk_ready = 1'b1;
        @(posedge clk);
        #1;
        m.bk_ready = 1'b0;
        check("pop_tready", m.axis_tready, 1);
        check("pop_data", m.bk_data, 32'h2);
        check("pop_count", m.bk_count, 3);
        drain();
        // streaming
        m.bk_ready = 1'b1;
        maxc = 0;
        track = 1'b1;
        t0 = int'($time);
        for (int i = 0; i < 20; i++) send(32'h100 + i, 2'(i), i == 19);
        check("stream_cycles", (int'($time) - t0) / 10, 20);
        drain();
        track = 1'b0;
        check("stream_maxcount", maxc, 1);
        // wrap with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 10; i++) send(32'hA0 + i, 2'(i + 1), (i % 3) == 2);
        #0 rand_bp = 1'b0;
        drain();
        check("wrap_queue", q.size(), 0);
        // reset mid-stream
        m.bk_ready = 1'b0;
        send(32'h11, 2'd1, 1'b0);
        send(32'h22, 2'd2, 1'b0);
        send(32'h33, 2'd3, 1'b1);
        check("mid_count", m.bk_count, 3);
        #2 aresetn = 1'b0;
        q.delete();
        #1;
        check("mid_rst_valid", m.bk_valid, 0);
        check("mid_rst_tready", m.axis_tready, 0);
        check("mid_rst_data", {m.bk_data, m.bk_user, m.bk_last}, 0);
        @(posedge clk);
        #2 aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_tready", m.axis_tready, 1);
        check("mid_rel_count", m.bk_count, 0);
        check("mid_rel_valid", m.bk_valid, 0);
        send(32'h55, 2'd1, 1'b1);
        drain();
        check("final_queue", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
